led_blink_sequencer: RTL and testbench
======================================

Name: led_blink_sequencer

Overview:
- Byte-commanded, N-channel LED blink engine; each channel runs its own on/off/gap state machine and timer.
- Takes bytes from the Bluetooth UART receiver through a valid/ready handshake.
- Drives the board LEDs: front/back corner LEDs, WF_LED.
- Adds four modes, per-channel addressing, repeat-with-gap, completion pulses and output polarity control.

Parameters:
- N_CH, 4, number of LED channels (1..4).
- HALF_CYC, 8000000, clock cycles per ON phase and per OFF phase (0.5 s at 16 MHz); must be >= 1.
- GAP_CYC, 32000000, clock cycles of the pause between bursts in REPEAT mode (2 s); must be >= 1.
- ACTIVE_LOW, 1, 1: led output 0 = lit; 0: led output 1 = lit.

Ports:
- WF_CLK  input  1  system clock.
- WF_BUTTON  input  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  input  1  cmd_data holds a command byte.
- cmd_data  input  8  [7:6] mode, [5:4] channel index, [3:0] count.
- cmd_ready  output  1  block accepts a command this cycle.
- led  output  N_CH  LED drive per channel, polarity set by ACTIVE_LOW.
- busy  output  N_CH  channel state is not IDLE.
- done  output  N_CH  one-cycle pulse when a BLINK_N burst completes.
- cmd_err  output  1  one-cycle pulse when a command names channel >= N_CH.

Behaviour:
- Reset (WF_BUTTON=0, asynchronous):
  - all channels IDLE, steady value off, timers and counters 0;
  - led = all unlit (all 1s if ACTIVE_LOW);
  - busy=0, done=0, cmd_err=0, cmd_ready=0;
  - any held command is discarded.
- Handshake:
  - cmd_ready=1 from the first cycle after reset release whenever the one-deep command register is empty.
  - Accept at edge t when cmd_valid && cmd_ready; byte is registered.
  - cmd_ready=0 in cycle t+1, while the register is applied; it returns to 1 in t+2. Peak rate is one command per 2 cycles.
- Apply at edge t+1:
  - channel field >= N_CH: drop the command and pulse cmd_err in cycle t+1; no channel changes.
  - otherwise the command overrides the addressed channel immediately, aborting any burst in progress (no done pulse for the aborted burst).
- Modes:
  - 00 BLINK_N: blink count times, then IDLE with steady off.
  - 01 ON: IDLE, steady lit.
  - 10 OFF: IDLE, steady unlit.
  - 11 REPEAT: blink count times, then GAP, then repeat indefinitely.
- Channel states:
  - IDLE: led = steady value. A BLINK_N or REPEAT command with count>=1 loads remaining=count and timer=0, then goes to ON.
  - ON: led lit for HALF_CYC cycles, then OFF with timer=0.
  - OFF: led unlit for HALF_CYC cycles. At phase end remaining decrements:
    - if the new value is >0, go to ON;
    - else BLINK_N goes to IDLE (steady off) and pulses done in the first IDLE cycle;
    - else REPEAT goes to GAP.
  - GAP: led unlit for GAP_CYC cycles, then ON with remaining reloaded from the stored count.
- Timing for a burst accepted at edge t: led lit in cycles t+2 .. t+1+HALF_CYC. The burst occupies exactly 2*HALF_CYC*count cycles, then done pulses.
- count=0:
  - BLINK_N: channel goes IDLE steady off, with done pulsed in cycle t+2.
  - REPEAT: IDLE steady off, no done pulse.
- Channels are fully independent. Commands to other channels never disturb a running channel.
- busy = (state != IDLE), registered alongside the state.
- Timer width is clog2(max(HALF_CYC, GAP_CYC)+1). Timers never wrap; each resets at phase end.
- Reset mid-burst: outputs go to reset values asynchronously; after release all channels are IDLE.

Test Plan:
- All tests use N_CH=4, HALF_CYC=4, GAP_CYC=10, ACTIVE_LOW=1.
- Release reset, send 0x03 (BLINK_N, ch0, 3) -> led[0] reads 0 for 4 cycles then 1 for 4, three times starting at t+2; busy[0]=1 throughout; done[0] pulses once at t+26; cmd_ready is 0 only in t+1.
- Send 0xD2 (REPEAT, ch1, 2), observe 60 cycles -> two 8-cycle blinks, 10-cycle unlit gap, repeat; done[1] never pulses; then 0x90 (OFF, ch1) mid-ON -> led[1]=1 and busy[1]=0 from the apply cycle.
- Send 0x41 (ON, ch0) while ch2 runs BLINK_N -> led[0]=0 steady; ch2 timing unchanged cycle-for-cycle.
- Hold cmd_valid high with 0x21 then 0x31 -> first accepted at t, second at t+2; ch2 and ch3 both blink once, offset by 2 cycles.
- Set N_CH=3, send 0x31 -> cmd_err pulses one cycle; no led or busy change. Send 0x00 -> done[0] pulses at t+2, led[0] stays 1.
- Assert reset during ch0 ON phase of a 5-blink burst -> led=4'b1111, busy=0 in the same cycle; after release, no activity without new commands.

Source files
------------

// File: rtl/led_blink_sequencer.sv
// Purpose : byte-commanded N-channel LED blink engine (BLINK_N / ON / OFF / REPEAT per channel).
// Latency : command accepted at edge t is applied at edge t+1; a burst lights its LED from cycle t+2.
// Backpressure: one-deep command register; cmd_ready drops for the apply cycle, so at most one command per 2 cycles.
//
// Ports:
//   WF_CLK    - system clock
//   WF_BUTTON - asynchronous active-low reset
//   cmd_valid / cmd_data / cmd_ready - command byte handshake: [7:6] mode, [5:4] channel, [3:0] count
//   led       - per-channel LED drive, lit level chosen by ACTIVE_LOW
//   busy      - channel is running a burst / gap (state != IDLE)
//   done      - one-cycle pulse when a BLINK_N burst completes
//   cmd_err   - one-cycle pulse while a command naming a missing channel is dropped
module led_blink_sequencer #(
  parameter int N_CH       = 4,
  parameter int HALF_CYC   = 8000000,
  parameter int GAP_CYC    = 32000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            WF_CLK,
  input  logic            WF_BUTTON,
  input  logic            cmd_valid,
  input  logic [7:0]      cmd_data,
  output logic            cmd_ready,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done,
  output logic            cmd_err
);

  localparam int MAX_CYC = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [2:0]    NCH3      = 3'(N_CH);

  localparam logic [1:0] M_BLINK = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_OFF   = 2'b10;
  localparam logic [1:0] M_REP   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} ch_state_t;

  // One-deep command register. cmd_ready is a flop so it stays low in reset
  // and through the first cycle after release, and drops for the apply cycle.
  logic       hold_vld;
  logic [7:0] hold_dat;
  logic       accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      cmd_ready <= 1'b0;
      hold_vld  <= 1'b0;
      hold_dat  <= 8'h00;
    end else begin
      cmd_ready <= !accept;
      hold_vld  <= accept;
      if (accept) hold_dat <= cmd_data;
    end
  end

  logic [1:0] hold_mode;
  logic [1:0] hold_ch;
  logic [3:0] hold_cnt;

  assign hold_mode = hold_dat[7:6];
  assign hold_ch   = hold_dat[5:4];
  assign hold_cnt  = hold_dat[3:0];

  // Dropped commands never match a channel below, so flagging here is enough.
  assign cmd_err = hold_vld && ({1'b0, hold_ch} >= NCH3);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    remain_q, remain_d;
    logic [3:0]    count_q, count_d;
    logic          rep_q, rep_d;
    logic          steady_q, steady_d;
    logic          done_q, done_d;
    logic          apply;
    logic          lit;
    logic [3:0]    remain_dec;

    assign apply      = hold_vld && (hold_ch == 2'(i));
    assign remain_dec = remain_q - 4'd1;

    always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
      if (!WF_BUTTON) begin
        state_q  <= ST_IDLE;
        timer_q  <= '0;
        remain_q <= 4'd0;
        count_q  <= 4'd0;
        rep_q    <= 1'b0;
        steady_q <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        timer_q  <= timer_d;
        remain_q <= remain_d;
        count_q  <= count_d;
        rep_q    <= rep_d;
        steady_q <= steady_d;
        done_q   <= done_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      remain_d = remain_q;
      count_d  = count_q;
      rep_d    = rep_q;
      steady_d = steady_q;
      done_d   = 1'b0;
      if (apply) begin
        // A new command always wins, even mid-burst; the aborted burst gets no done.
        timer_d = '0;
        case (hold_mode)
          M_ON: begin
            state_d  = ST_IDLE;
            steady_d = 1'b1;
          end
          M_OFF: begin
            state_d  = ST_IDLE;
            steady_d = 1'b0;
          end
          default: begin
            steady_d = 1'b0;
            rep_d    = (hold_mode == M_REP);
            count_d  = hold_cnt;
            remain_d = hold_cnt;
            if (hold_cnt == 4'd0) begin
              state_d = ST_IDLE;
              done_d  = (hold_mode == M_BLINK);
            end else begin
              state_d = ST_ON;
            end
          end
        endcase
      end else begin
        case (state_q)
          ST_ON: begin
            if (timer_q == HALF_LAST) begin
              state_d = ST_OFF;
              timer_d = '0;
            end else begin
              timer_d = timer_q + T_ONE;
            end
          end
          ST_OFF: begin
            if (timer_q == HALF_LAST) begin
              timer_d  = '0;
              remain_d = remain_dec;
              if (remain_dec != 4'd0) begin
                state_d = ST_ON;
              end else if (rep_q) begin
                state_d = ST_GAP;
              end else begin
                state_d  = ST_IDLE;
                steady_d = 1'b0;
                done_d   = 1'b1;
              end
            end else begin
              timer_d = timer_q + T_ONE;
            end
          end
          ST_GAP: begin
            if (timer_q == GAP_LAST) begin
              state_d  = ST_ON;
              timer_d  = '0;
              remain_d = count_q;
            end else begin
              timer_d = timer_q + T_ONE;
            end
          end
          default: begin
          end
        endcase
      end
    end

    assign lit     = (state_q == ST_ON) || ((state_q == ST_IDLE) && steady_q);
    assign led[i]  = lit ^ ACTIVE_LOW;
    assign busy[i] = (state_q != ST_IDLE);
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Purpose : self-checking bench for led_blink_sequencer (4-channel and 3-channel builds).
// Latency : expectations keyed by cycle number; cycle c is sampled on the falling edge after rising edge c-1.
// Backpressure: commands are driven only when cmd_ready is expected high; held-valid case checks the 2-cycle spacing.
module tb_led_blink_sequencer;

  localparam int H  = 4;
  localparam int G  = 10;
  localparam int HB = 2 * H;

  localparam int S_LED  = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;
  localparam int S_RDY  = 3;
  localparam int S_ERR  = 4;

  logic       WF_CLK;
  logic       WF_BUTTON;
  logic       v0, v3;
  logic [7:0] d0, d3;
  logic       rdy0, rdy3;
  logic [3:0] led0, busy0, done0;
  logic [2:0] led3, busy3, done3;
  logic       err0, err3;
  logic [3:0] led3w, busy3w, done3w;

  assign led3w  = {1'b1, led3};
  assign busy3w = {1'b0, busy3};
  assign done3w = {1'b0, done3};

  led_blink_sequencer #(.N_CH(4), .HALF_CYC(H), .GAP_CYC(G), .ACTIVE_LOW(1'b1)) dut (
    .WF_CLK(WF_CLK), .WF_BUTTON(WF_BUTTON), .cmd_valid(v0), .cmd_data(d0), .cmd_ready(rdy0),
    .led(led0), .busy(busy0), .done(done0), .cmd_err(err0));

  led_blink_sequencer #(.N_CH(3), .HALF_CYC(H), .GAP_CYC(G), .ACTIVE_LOW(1'b1)) dut3 (
    .WF_CLK(WF_CLK), .WF_BUTTON(WF_BUTTON), .cmd_valid(v3), .cmd_data(d3), .cmd_ready(rdy3),
    .led(led3), .busy(busy3), .done(done3), .cmd_err(err3));

  initial WF_CLK = 1'b0;
  always #5 WF_CLK = ~WF_CLK;

  int cyc = 0;
  always @(posedge WF_CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int   d;
    int   sig;
    int   idx;
    int   cyc;
    logic val;
  } sb_t;

  sb_t   sbq[$];
  string sn[5] = '{"led", "busy", "done", "rdy", "err"};

  task automatic push(input int d, input int sig, input int idx, input int c, input logic v);
    sb_t e;
    int  pos;
    e   = '{d, sig, idx, c, v};
    pos = sbq.size();
    while (pos > 0 && sbq[pos-1].cyc > c) pos--;
    sbq.insert(pos, e);
  endtask

  function automatic logic get_sig(input int d, input int sig, input int idx);
    case (sig)
      S_LED:   return (d == 0) ? led0[idx]  : led3w[idx];
      S_BUSY:  return (d == 0) ? busy0[idx] : busy3w[idx];
      S_DONE:  return (d == 0) ? done0[idx] : done3w[idx];
      S_RDY:   return (d == 0) ? rdy0 : rdy3;
      default: return (d == 0) ? err0 : err3;
    endcase
  endfunction

  always @(negedge WF_CLK) begin : sb_check
    int  scyc;
    sb_t e;
    scyc = cyc + 1;
    while (sbq.size() > 0 && sbq[0].cyc <= scyc) begin
      e = sbq.pop_front();
      if (e.cyc < scyc)
        chk($sformatf("sb_stale_d%0d_%s[%0d]@%0d", e.d, sn[e.sig], e.idx, e.cyc), 4'h1, 4'h0);
      else
        chk($sformatf("d%0d_%s[%0d]@%0d", e.d, sn[e.sig], e.idx, e.cyc),
            {3'b000, get_sig(e.d, e.sig, e.idx)}, {3'b000, e.val});
    end
  end

  // Expected led/busy/done for a burst accepted at edge t, over cycles lo..hi.
  // BLINK_N: lit for H, unlit for H, cnt times, then idle off with done on the first idle cycle.
  // REPEAT : same blinks followed by a G-cycle unlit gap, period 2*H*cnt+G.
  task automatic exp_blink(input int d, input int ch, input int t, input int cnt,
                           input int lo, input int hi, input bit rep);
    for (int c = lo; c <= hi; c++) begin
      int   o;
      logic lit, bsy, dn;
      o = c - (t + 2);
      if (rep) o = o % (HB * cnt + G);
      dn = 1'b0;
      if (o >= HB * cnt) begin
        lit = 1'b0;
        bsy = rep;
        dn  = !rep && (o == HB * cnt);
      end else begin
        lit = ((o % HB) < H);
        bsy = 1'b1;
      end
      push(d, S_LED, ch, c, ~lit);
      push(d, S_BUSY, ch, c, bsy);
      push(d, S_DONE, ch, c, dn);
    end
  endtask

  task automatic exp_level(input int d, input int ch, input int lo, input int hi, input logic ledv);
    for (int c = lo; c <= hi; c++) begin
      push(d, S_LED, ch, c, ledv);
      push(d, S_BUSY, ch, c, 1'b0);
      push(d, S_DONE, ch, c, 1'b0);
    end
  endtask

  task automatic exp_hs(input int d, input int t, input logic e);
    push(d, S_RDY, 0, t + 1, 1'b0);
    push(d, S_RDY, 0, t + 2, 1'b1);
    push(d, S_ERR, 0, t + 1, e);
    push(d, S_ERR, 0, t + 2, 1'b0);
  endtask

  task automatic wait_until(input int c);
    while (cyc + 1 < c) @(negedge WF_CLK);
  endtask

  // Called on a falling edge; the command is accepted on the following rising edge t.
  task automatic send(input int d, input logic [7:0] c, output int t);
    chk($sformatf("d%0d_rdy_before_%02h", d, c), {3'b000, (d == 0) ? rdy0 : rdy3}, 4'h1);
    if (d == 0) begin v0 = 1'b1; d0 = c; end
    else        begin v3 = 1'b1; d3 = c; end
    t = cyc + 1;
    @(posedge WF_CLK);
    #1;
    v0 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_led0"},  led0,  4'b1111);
    chk({tag, "_busy0"}, busy0, 4'b0000);
    chk({tag, "_done0"}, done0, 4'b0000);
    chk({tag, "_err0"},  {3'b000, err0}, 4'h0);
    chk({tag, "_rdy0"},  {3'b000, rdy0}, 4'h0);
    chk({tag, "_led3"},  {1'b0, led3},  4'b0111);
    chk({tag, "_busy3"}, {1'b0, busy3}, 4'b0000);
    chk({tag, "_rdy3"},  {3'b000, rdy3}, 4'h0);
  endtask

  // Table for the 3-channel build: command and the outcome it must produce.
  typedef struct {
    logic [7:0] cmd;
    bit         err;
    int         ch;
    bit         isblink;
    int         blinks;
    logic       ledv;
    int         span;
  } vec_t;

  vec_t vt[8];
  logic lvl3[3];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t, t2, t3, t4, t5, t6;

    vt[0] = '{8'h31, 1'b1, 0, 1'b0, 0, 1'b1, 6};   // channel 3 absent
    vt[1] = '{8'h00, 1'b0, 0, 1'b1, 0, 1'b1, 6};   // BLINK_N count 0: done at t+2
    vt[2] = '{8'h61, 1'b0, 2, 1'b0, 0, 1'b0, 6};   // ON ch2
    vt[3] = '{8'hD0, 1'b0, 1, 1'b0, 0, 1'b1, 6};   // REPEAT count 0: off, no done
    vt[4] = '{8'h12, 1'b0, 1, 1'b1, 2, 1'b1, 22};  // BLINK_N ch1 x2
    vt[5] = '{8'hA0, 1'b0, 2, 1'b0, 0, 1'b1, 6};   // OFF ch2
    vt[6] = '{8'hF5, 1'b1, 0, 1'b0, 0, 1'b1, 6};   // channel 3 absent
    vt[7] = '{8'h7F, 1'b1, 0, 1'b0, 0, 1'b1, 6};   // channel 3 absent
    for (int c = 0; c < 3; c++) lvl3[c] = 1'b1;

    WF_BUTTON = 1'b0;
    v0 = 1'b0; d0 = 8'h00;
    v3 = 1'b0; d3 = 8'h00;

    repeat (3) @(negedge WF_CLK);
    chk_reset("reset");
    WF_BUTTON = 1'b1;
    @(negedge WF_CLK);
    chk("rdy_after_release", {3'b000, rdy0}, 4'h1);

    // BLINK_N ch0 x3
    send(0, 8'h03, t);
    exp_hs(0, t, 1'b0);
    exp_level(0, 0, t + 1, t + 1, 1'b1);
    exp_blink(0, 0, t, 3, t + 2, t + 30, 1'b0);
    wait_until(t + 31);

    // REPEAT ch1 x2, then OFF while in the second ON phase
    send(0, 8'hD2, t);
    exp_hs(0, t, 1'b0);
    exp_level(0, 1, t + 1, t + 1, 1'b1);
    exp_blink(0, 1, t, 2, t + 2, t + 63, 1'b1);
    wait_until(t + 62);
    send(0, 8'h90, t2);
    exp_hs(0, t2, 1'b0);
    exp_level(0, 1, t2 + 2, t2 + 11, 1'b1);
    wait_until(t2 + 12);

    // ch2 BLINK_N x3, ON to ch0 mid-burst leaves ch2 untouched
    send(0, 8'h23, t3);
    exp_hs(0, t3, 1'b0);
    exp_level(0, 2, t3 + 1, t3 + 1, 1'b1);
    exp_blink(0, 2, t3, 3, t3 + 2, t3 + 30, 1'b0);
    exp_level(0, 1, t3 + 1, t3 + 30, 1'b1);
    wait_until(t3 + 5);
    send(0, 8'h41, t4);
    exp_hs(0, t4, 1'b0);
    exp_level(0, 0, t4 + 1, t4 + 1, 1'b1);
    exp_level(0, 0, t4 + 2, t3 + 30, 1'b0);
    wait_until(t3 + 31);

    // cmd_valid held across two commands: second is taken two edges later
    chk("rdy_before_hold", {3'b000, rdy0}, 4'h1);
    v0 = 1'b1; d0 = 8'h21;
    t5 = cyc + 1;
    @(posedge WF_CLK);
    #1;
    d0 = 8'h31;
    push(0, S_RDY, 0, t5 + 1, 1'b0);
    push(0, S_RDY, 0, t5 + 2, 1'b1);
    push(0, S_RDY, 0, t5 + 3, 1'b0);
    push(0, S_RDY, 0, t5 + 4, 1'b1);
    exp_level(0, 2, t5 + 1, t5 + 1, 1'b1);
    exp_blink(0, 2, t5, 1, t5 + 2, t5 + 12, 1'b0);
    exp_level(0, 3, t5 + 1, t5 + 3, 1'b1);
    exp_blink(0, 3, t5 + 2, 1, t5 + 4, t5 + 14, 1'b0);
    @(posedge WF_CLK);
    @(posedge WF_CLK);
    #1;
    v0 = 1'b0;
    wait_until(t5 + 15);

    // Table-driven commands on the 3-channel build
    for (int i = 0; i < 8; i++) begin
      send(1, vt[i].cmd, t);
      exp_hs(1, t, vt[i].err);
      for (int c = 3; c <= vt[i].span; c++) push(1, S_ERR, 0, t + c, 1'b0);
      for (int c = 0; c < 3; c++) begin
        if (vt[i].err || c != vt[i].ch) begin
          exp_level(1, c, t + 1, t + vt[i].span, lvl3[c]);
        end else begin
          exp_level(1, c, t + 1, t + 1, lvl3[c]);
          if (vt[i].isblink)
            exp_blink(1, c, t, vt[i].blinks, t + 2, t + vt[i].span, 1'b0);
          else
            exp_level(1, c, t + 2, t + vt[i].span, vt[i].ledv);
          lvl3[c] = vt[i].ledv;
        end
      end
      wait_until(t + vt[i].span);
    end
    wait_until(t + vt[7].span + 1);

    // Reset asserted during ch0's first ON phase of a 5-blink burst
    send(0, 8'h05, t6);
    exp_hs(0, t6, 1'b0);
    exp_blink(0, 0, t6, 5, t6 + 2, t6 + 5, 1'b0);
    wait_until(t6 + 5);
    #2;
    WF_BUTTON = 1'b0;
    #1;
    chk_reset("async_reset");
    repeat (3) begin
      @(negedge WF_CLK);
      chk_reset("in_reset");
    end
    WF_BUTTON = 1'b1;
    repeat (20) begin
      @(negedge WF_CLK);
      chk("post_reset_led0", led0, 4'b1111);
      chk("post_reset_busy0", busy0, 4'b0000);
      chk("post_reset_done0", done0, 4'b0000);
      chk("post_reset_led3", {1'b0, led3}, 4'b0111);
    end

    chk("sb_drained", 4'(sbq.size()), 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
